// File: rtl/shift_ctrl_pkg.sv
// shift_ctrl_pkg
//   Shared definitions for the shift_ctrl sequencer: FSM state encoding,
//   the window geometry (3 rows x 2 words) and the packed pixel word width.
//   No ports; imported by the interface, the address generator and the top.

package shift_ctrl_pkg;

    localparam int WIN_ROWS = 3;   // rows covered by one window
    localparam int WIN_COLS = 2;   // 32-bit words per window row
    localparam int PIX_W    = 32;  // packed pixel word width

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WIN   = 2'd2
    } state_t;

endpackage : shift_ctrl_pkg

// File: rtl/shift_ctrl_if.sv
// shift_ctrl_if
//   Bundles the three data-side ports of the sequencer:
//     memory read port : rd_req, rd_addr (to memory), rd_ack, rd_data (from memory)
//     datapath drive   : dp_write_en, dp_data (to shift_data_path)
//     window handshake : win_valid, win_addr (to Sobel engine), win_ready (from it)
//
//   Handshake rules (both channels): a transfer happens on a rising clk edge
//   where the producer's valid (rd_req / win_valid) and the consumer's
//   acceptance (rd_ack / win_ready) are both high. The producer holds its
//   address stable while valid is high and not yet accepted. Acceptance seen
//   while valid is low is ignored. rd_data is valid in the same cycle as rd_ack.
//
//   Modports: master = shift_ctrl side, slave = memory/datapath/engine side.

interface shift_ctrl_if
    import shift_ctrl_pkg::*;
#(
    parameter int ADDR_W = 17
);

    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic [PIX_W-1:0]  rd_data;

    logic              dp_write_en;
    logic [PIX_W-1:0]  dp_data;

    logic              win_valid;
    logic              win_ready;
    logic [ADDR_W-1:0] win_addr;

    modport master (
        output rd_req, rd_addr, dp_write_en, dp_data, win_valid, win_addr,
        input  rd_ack, rd_data, win_ready
    );

    modport slave (
        input  rd_req, rd_addr, dp_write_en, dp_data, win_valid, win_addr,
        output rd_ack, rd_data, win_ready
    );

endinterface : shift_ctrl_if

// File: rtl/shift_addr_gen.sv
// shift_addr_gen
//   Position and address state for shift_ctrl. Keeps three source row
//   pointers (column-0 address of rows r-1, r, r+1), the destination row
//   pointer (column-0 address of result row r), and the r/c/k counters.
//   Addresses advance by adding IMG_W per row, so no multiplier is needed.
//
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     load                  start a frame: latch bases, r=1, c=0, k=0
//     step_k                advance to the next row of the current column
//     step_col              c++, k=0
//     step_row              r++, c=0, k=0, all row pointers += IMG_W
//     src_base, dst_base    frame bases, used on load
//     rd_addr               src word (r-1+k, c)
//     win_addr              dst word (r, c-1)
//     last_k                k is on the bottom row of the window
//     col_ready             c >= 1, i.e. the datapath holds a full window
//     last_col, last_row    c == IMG_W-1, r == IMG_H-2

module shift_addr_gen
    import shift_ctrl_pkg::*;
#(
    parameter int IMG_W  = 160,
    parameter int IMG_H  = 480,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step_k,
    input  logic              step_col,
    input  logic              step_row,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] win_addr,
    output logic              last_k,
    output logic              col_ready,
    output logic              last_col,
    output logic              last_row
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] ROW_STEP2 = ADDR_W'(2 * IMG_W);

    logic [ADDR_W-1:0] row_ptr [WIN_ROWS];
    logic [ADDR_W-1:0] dst_row;
    logic [CW-1:0]     c;
    logic [RW-1:0]     r;
    logic [1:0]        k;
    logic [ADDR_W-1:0] row_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WIN_ROWS; i++) begin
                row_ptr[i] <= '0;
            end
            dst_row <= '0;
            r       <= '0;
            c       <= '0;
            k       <= '0;
        end else if (load) begin
            // First window is centred on row 1, so it spans rows 0..2.
            row_ptr[0] <= src_base;
            row_ptr[1] <= src_base + ROW_STEP;
            row_ptr[2] <= src_base + ROW_STEP2;
            dst_row    <= dst_base + ROW_STEP;
            r          <= RW'(1);
            c          <= '0;
            k          <= '0;
        end else if (step_row) begin
            for (int i = 0; i < WIN_ROWS; i++) begin
                row_ptr[i] <= row_ptr[i] + ROW_STEP;
            end
            dst_row <= dst_row + ROW_STEP;
            r       <= r + RW'(1);
            c       <= '0;
            k       <= '0;
        end else if (step_col) begin
            c <= c + CW'(1);
            k <= '0;
        end else if (step_k) begin
            k <= k + 2'd1;
        end
    end

    always_comb begin
        row_sel = row_ptr[0];
        if (k == 2'd1) begin
            row_sel = row_ptr[1];
        end else if (k == 2'd2) begin
            row_sel = row_ptr[2];
        end
    end

    assign rd_addr  = row_sel + ADDR_W'(c);
    // The window just completed ends at column c, so its centre-left word is c-1.
    assign win_addr = dst_row + ADDR_W'(c) - ADDR_W'(1);

    assign last_k    = (k == 2'(WIN_ROWS - 1));
    assign col_ready = (c >= CW'(WIN_COLS - 1));
    assign last_col  = (c == CW'(IMG_W - 1));
    assign last_row  = (r == RW'(IMG_H - 2));

endmodule : shift_addr_gen

// File: rtl/shift_ctrl.sv
// shift_ctrl
//   Frame sequencer for shift_data_path. For every window position it reads
//   the three words of one column (rows r-1, r, r+1) from image memory,
//   passes each acked word straight to the datapath, and once two columns
//   are loaded presents the window to the Sobel engine with its destination
//   address. One frame runs per accepted start.
//
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     start                 one-cycle frame start, ignored while busy
//     src_base, dst_base    frame word bases, latched on accepted start
//     busy                  frame in progress
//     done                  one-cycle pulse after the last window transfer
//     state_dbg             current FSM state
//     bus                   memory read, datapath drive and window channels

module shift_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int IMG_W  = 160,
    parameter int IMG_H  = 480,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    output logic              busy,
    output logic              done,
    output state_t            state_dbg,
    shift_ctrl_if.master      bus
);

    generate
        if (IMG_W < 2 || IMG_H < 3) begin : g_bad_params
            $error("shift_ctrl: IMG_W must be >= 2 and IMG_H must be >= 3");
        end
    endgenerate

    state_t state, state_n;
    logic   done_q, done_n;

    logic load, step_k, step_col, step_row;
    logic last_k, col_ready, last_col, last_row;

    logic [ADDR_W-1:0] gen_rd_addr;
    logic [ADDR_W-1:0] gen_win_addr;

    logic             rd_req;
    logic             dp_write_en;
    logic [PIX_W-1:0] dp_data;
    logic             win_valid;

    shift_addr_gen #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .step_k    (step_k),
        .step_col  (step_col),
        .step_row  (step_row),
        .src_base  (src_base),
        .dst_base  (dst_base),
        .rd_addr   (gen_rd_addr),
        .win_addr  (gen_win_addr),
        .last_k    (last_k),
        .col_ready (col_ready),
        .last_col  (last_col),
        .last_row  (last_row)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            done_q <= done_n;
        end
    end

    always_comb begin
        state_n     = state;
        done_n      = 1'b0;
        load        = 1'b0;
        step_k      = 1'b0;
        step_col    = 1'b0;
        step_row    = 1'b0;
        rd_req      = 1'b0;
        dp_write_en = 1'b0;
        dp_data     = '0;
        win_valid   = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_n = ST_FETCH;
                end
            end

            ST_FETCH: begin
                rd_req = 1'b1;
                if (bus.rd_ack) begin
                    // Datapath shifts on the same edge the memory accepts.
                    dp_write_en = 1'b1;
                    dp_data     = bus.rd_data;
                    if (!last_k) begin
                        step_k = 1'b1;
                    end else if (col_ready) begin
                        // k stays at the bottom row; leaving WIN clears it.
                        state_n = ST_WIN;
                    end else begin
                        // First column of a row only primes the window.
                        step_col = 1'b1;
                    end
                end
            end

            ST_WIN: begin
                win_valid = 1'b1;
                if (bus.win_ready) begin
                    if (!last_col) begin
                        step_col = 1'b1;
                        state_n  = ST_FETCH;
                    end else if (!last_row) begin
                        step_row = 1'b1;
                        state_n  = ST_FETCH;
                    end else begin
                        done_n  = 1'b1;
                        state_n = ST_IDLE;
                    end
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign busy      = (state != ST_IDLE);
    assign done      = done_q;
    assign state_dbg = state;

    // Addresses read as zero outside the state that presents them.
    assign bus.rd_req      = rd_req;
    assign bus.rd_addr     = (state == ST_FETCH) ? gen_rd_addr : '0;
    assign bus.dp_write_en = dp_write_en;
    assign bus.dp_data     = dp_data;
    assign bus.win_valid   = win_valid;
    assign bus.win_addr    = (state == ST_WIN) ? gen_win_addr : '0;

endmodule : shift_ctrl

// File: tb/tb_shift_ctrl.sv
module tb_shift_ctrl;
    import shift_ctrl_pkg::*;

    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] src_base = '0;
    logic [AW-1:0] dst_base = '0;
    logic          rd_ack = 1'b0;
    logic [31:0]   rd_data = '0;
    logic          win_ready = 1'b0;

    logic   busy3, done3, busy4, done4;
    state_t st3, st4;

    int tests_run = 0;
    int tests_failed = 0;

    shift_ctrl_if #(.ADDR_W(AW)) if3 ();
    shift_ctrl_if #(.ADDR_W(AW)) if4 ();

    assign if3.rd_ack    = rd_ack;
    assign if3.rd_data   = rd_data;
    assign if3.win_ready = win_ready;
    assign if4.rd_ack    = rd_ack;
    assign if4.rd_data   = rd_data;
    assign if4.win_ready = win_ready;

    shift_ctrl #(.IMG_W(4), .IMG_H(3), .ADDR_W(AW)) dut3 (
        .clk(clk), .reset(reset), .start(start), .src_base(src_base), .dst_base(dst_base),
        .busy(busy3), .done(done3), .state_dbg(st3), .bus(if3)
    );

    shift_ctrl #(.IMG_W(4), .IMG_H(4), .ADDR_W(AW)) dut4 (
        .clk(clk), .reset(reset), .start(start), .src_base(src_base), .dst_base(dst_base),
        .busy(busy4), .done(done4), .state_dbg(st4), .bus(if4)
    );

    // clock / reset
    always #5 clk = ~clk;

    // transfer logs, filled mid-low-phase after inputs have settled
    bit            log_en = 1'b0;
    logic [AW-1:0] rd_log3[$], win_log3[$], rd_log4[$], win_log4[$];
    logic [31:0]   dp_log[$], dp_exp[$];
    logic          dpwe_log[$];

    always begin
        @(negedge clk);
        #3;
        if (log_en) begin
            if (if3.rd_req && rd_ack) begin
                rd_log3.push_back(if3.rd_addr);
                dp_log.push_back(if3.dp_data);
                dp_exp.push_back(rd_data);
                dpwe_log.push_back(if3.dp_write_en);
            end
            if (if3.win_valid && win_ready) win_log3.push_back(if3.win_addr);
            if (if4.rd_req && rd_ack) rd_log4.push_back(if4.rd_addr);
            if (if4.win_valid && win_ready) win_log4.push_back(if4.win_addr);
        end
    end

    // per-frame observations
    int            lat3, done_cnt3;
    logic          busy_at1, rdreq_at1, busy_at_done;
    logic [AW-1:0] addr_at1;
    logic [AW-1:0] rs_addr_q[$], ws_addr_q[$];
    logic          rs_we_q[$], ws_valid_q[$], ws_rdreq_q[$];

    // driver: runs one frame with optional memory stall, engine stall,
    // extra start pulse, or reset abort (reset left asserted on abort)
    task automatic run_frame(input int rd_stall_idx, input int rd_stall_len,
                             input int win_stall_len, input int busy_start_n,
                             input int reset_read_idx);
        int  n, reads3, wins3, rstall, wstall;
        bit  finished, rs_now, ws_now;
        rd_log3.delete(); win_log3.delete(); rd_log4.delete(); win_log4.delete();
        dp_log.delete(); dp_exp.delete(); dpwe_log.delete();
        rs_addr_q.delete(); rs_we_q.delete();
        ws_addr_q.delete(); ws_valid_q.delete(); ws_rdreq_q.delete();
        lat3 = -1; done_cnt3 = 0; busy_at_done = 1'b1;
        log_en = 1'b1;
        @(negedge clk);
        src_base = 17'h100; dst_base = 17'h200; start = 1'b1;
        rd_ack = 1'b1; win_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1; reads3 = 0; wins3 = 0; rstall = 0; wstall = 0; finished = 1'b0;
        while (n < 300 && !finished) begin
            start = (n == busy_start_n);
            if (n == busy_start_n) begin
                src_base = 17'h300; dst_base = 17'h500;
            end
            rd_data = $urandom;
            #1;
            rd_ack = 1'b1; win_ready = 1'b1; rs_now = 1'b0; ws_now = 1'b0;
            if (reset_read_idx >= 0 && reads3 == reset_read_idx && if3.rd_req) begin
                reset = 1'b1; finished = 1'b1;
            end
            if (rd_stall_idx >= 0 && reads3 == rd_stall_idx && rstall < rd_stall_len && if3.rd_req) begin
                rd_ack = 1'b0; rstall++; rs_now = 1'b1;
            end
            if (if3.win_valid && wins3 == 0 && wstall < win_stall_len) begin
                win_ready = 1'b0; wstall++; ws_now = 1'b1;
            end
            #1;
            if (rs_now) begin
                rs_addr_q.push_back(if3.rd_addr);
                rs_we_q.push_back(if3.dp_write_en);
            end
            if (ws_now) begin
                ws_valid_q.push_back(if3.win_valid);
                ws_addr_q.push_back(if3.win_addr);
                ws_rdreq_q.push_back(if3.rd_req);
            end
            if (n == 1) begin
                busy_at1 = busy3; rdreq_at1 = if3.rd_req; addr_at1 = if3.rd_addr;
            end
            if (if3.rd_req && rd_ack) reads3++;
            if (if3.win_valid && win_ready) wins3++;
            if (done3) begin
                done_cnt3++;
                if (lat3 < 0) begin
                    lat3 = n; busy_at_done = busy3;
                end
            end
            if (lat3 >= 0 && !busy3 && !busy4 && !done3) finished = 1'b1;
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (!finished) begin
            tests_failed++;
            $display("FAIL frame_timeout: ran %0d cycles, required completion", n);
        end
        start = 1'b0; src_base = 17'h100; dst_base = 17'h200;
        log_en = 1'b0;
    endtask

    // expected read/window lists for the 4-wide frame, rows centred on r
    task automatic test_reads3(input string tag);
        logic [AW-1:0] e;
        tests_run++;
        if (rd_log3.size() !== 12) begin
            tests_failed++;
            $display("FAIL %s_read_count: got %0d expected 12", tag, rd_log3.size());
        end
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 3; k++) begin
                if (c * 3 + k < rd_log3.size()) begin
                    e = 17'h100 + 17'(k * 4 + c);
                    tests_run++;
                    if (rd_log3[c * 3 + k] !== e) begin
                        tests_failed++;
                        $display("FAIL %s_rd_addr[%0d]: got %h expected %h", tag, c * 3 + k, rd_log3[c * 3 + k], e);
                    end
                end
            end
        end
        tests_run++;
        if (win_log3.size() !== 3) begin
            tests_failed++;
            $display("FAIL %s_win_count: got %0d expected 3", tag, win_log3.size());
        end
        for (int i = 0; i < 3 && i < win_log3.size(); i++) begin
            e = 17'h204 + 17'(i);
            tests_run++;
            if (win_log3[i] !== e) begin
                tests_failed++;
                $display("FAIL %s_win_addr[%0d]: got %h expected %h", tag, i, win_log3[i], e);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        rd_ack = 1'b1; win_ready = 1'b1;
        #2;
        tests_run++;
        if (busy3 !== 1'b0 || done3 !== 1'b0 || st3 !== ST_IDLE) begin
            tests_failed++;
            $display("FAIL reset_ctrl: busy=%b done=%b state=%0d expected 0 0 0", busy3, done3, st3);
        end
        tests_run++;
        if (if3.rd_req !== 1'b0 || if3.rd_addr !== '0 || if3.dp_write_en !== 1'b0 || if3.dp_data !== '0) begin
            tests_failed++;
            $display("FAIL reset_rd: req=%b addr=%h we=%b data=%h expected zeros", if3.rd_req, if3.rd_addr, if3.dp_write_en, if3.dp_data);
        end
        tests_run++;
        if (if3.win_valid !== 1'b0 || if3.win_addr !== '0) begin
            tests_failed++;
            $display("FAIL reset_win: valid=%b addr=%h expected 0 0", if3.win_valid, if3.win_addr);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_frame();
        run_frame(-1, 0, 0, -1, -1);
        tests_run++;
        if (busy_at1 !== 1'b1 || rdreq_at1 !== 1'b1 || addr_at1 !== 17'h100) begin
            tests_failed++;
            $display("FAIL basic_first_cycle: busy=%b req=%b addr=%h expected 1 1 100", busy_at1, rdreq_at1, addr_at1);
        end
        test_reads3("basic");
        tests_run++;
        if (lat3 !== 16) begin
            tests_failed++;
            $display("FAIL basic_done_latency: got %0d expected 16", lat3);
        end
        tests_run++;
        if (done_cnt3 !== 1 || busy_at_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_done_pulse: cycles=%0d busy=%b expected 1 0", done_cnt3, busy_at_done);
        end
        for (int i = 0; i < dp_log.size(); i++) begin
            tests_run++;
            if (dp_log[i] !== dp_exp[i] || dpwe_log[i] !== 1'b1) begin
                tests_failed++;
                $display("FAIL basic_dp[%0d]: data=%h we=%b expected %h 1", i, dp_log[i], dpwe_log[i], dp_exp[i]);
            end
        end
    endtask

    task automatic test_two_rows();
        logic [AW-1:0] e;
        run_frame(-1, 0, 0, -1, -1);
        tests_run++;
        if (rd_log4.size() !== 24 || win_log4.size() !== 6) begin
            tests_failed++;
            $display("FAIL rows_counts: reads=%0d wins=%0d expected 24 6", rd_log4.size(), win_log4.size());
        end
        for (int i = 0; i < 24 && i < rd_log4.size(); i++) begin
            e = 17'h100 + 17'((i / 12) * 4 + (i % 3) * 4 + (i % 12) / 3);
            tests_run++;
            if (rd_log4[i] !== e) begin
                tests_failed++;
                $display("FAIL rows_rd_addr[%0d]: got %h expected %h", i, rd_log4[i], e);
            end
        end
        for (int i = 0; i < 6 && i < win_log4.size(); i++) begin
            e = 17'h204 + 17'((i / 3) * 4 + (i % 3));
            tests_run++;
            if (win_log4[i] !== e) begin
                tests_failed++;
                $display("FAIL rows_win_addr[%0d]: got %h expected %h", i, win_log4[i], e);
            end
        end
    endtask

    task automatic test_mem_stall();
        run_frame(1, 5, 0, -1, -1);
        tests_run++;
        if (rs_addr_q.size() !== 5) begin
            tests_failed++;
            $display("FAIL mstall_cycles: got %0d expected 5", rs_addr_q.size());
        end
        for (int i = 0; i < rs_addr_q.size(); i++) begin
            tests_run++;
            if (rs_addr_q[i] !== 17'h104 || rs_we_q[i] !== 1'b0) begin
                tests_failed++;
                $display("FAIL mstall_hold[%0d]: addr=%h we=%b expected 104 0", i, rs_addr_q[i], rs_we_q[i]);
            end
        end
        test_reads3("mstall");
        tests_run++;
        if (lat3 !== 21) begin
            tests_failed++;
            $display("FAIL mstall_latency: got %0d expected 21", lat3);
        end
    endtask

    task automatic test_engine_stall();
        run_frame(-1, 0, 4, -1, -1);
        tests_run++;
        if (ws_addr_q.size() !== 4) begin
            tests_failed++;
            $display("FAIL estall_cycles: got %0d expected 4", ws_addr_q.size());
        end
        for (int i = 0; i < ws_addr_q.size(); i++) begin
            tests_run++;
            if (ws_valid_q[i] !== 1'b1 || ws_addr_q[i] !== 17'h204 || ws_rdreq_q[i] !== 1'b0) begin
                tests_failed++;
                $display("FAIL estall_hold[%0d]: valid=%b addr=%h req=%b expected 1 204 0", i, ws_valid_q[i], ws_addr_q[i], ws_rdreq_q[i]);
            end
        end
        test_reads3("estall");
        tests_run++;
        if (lat3 !== 20) begin
            tests_failed++;
            $display("FAIL estall_latency: got %0d expected 20", lat3);
        end
    endtask

    task automatic test_start_busy();
        run_frame(-1, 0, 0, 5, -1);
        test_reads3("restart");
        tests_run++;
        if (lat3 !== 16) begin
            tests_failed++;
            $display("FAIL restart_latency: got %0d expected 16", lat3);
        end
    endtask

    task automatic test_reset_mid();
        run_frame(-1, 0, 0, -1, 6);
        #2;
        tests_run++;
        if (busy3 !== 1'b0 || done3 !== 1'b0 || st3 !== ST_IDLE || if3.rd_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_ctrl: busy=%b done=%b state=%0d req=%b expected 0 0 0 0", busy3, done3, st3, if3.rd_req);
        end
        tests_run++;
        if (if3.rd_addr !== '0 || if3.dp_write_en !== 1'b0 || if3.dp_data !== '0 ||
            if3.win_valid !== 1'b0 || if3.win_addr !== '0) begin
            tests_failed++;
            $display("FAIL midreset_bus: addr=%h we=%b data=%h wv=%b wa=%h expected zeros", if3.rd_addr, if3.dp_write_en, if3.dp_data, if3.win_valid, if3.win_addr);
        end
        reset = 1'b0;
        @(negedge clk);
        run_frame(-1, 0, 0, -1, -1);
        test_reads3("replay");
        tests_run++;
        if (lat3 !== 16) begin
            tests_failed++;
            $display("FAIL replay_latency: got %0d expected 16", lat3);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_two_rows();
        test_mem_stall();
        test_engine_stall();
        test_start_busy();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_shift_ctrl
